// File: rtl/sobel_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_frame_ctrl_if
//  Purpose  : Bundles the control handshake between a frame sequencer
//             (master: regfile / pixel source) and sobel_frame_ctrl (slave).
//  Signals  : start, abort, pix_valid       master -> slave
//             enable_lb, enable_conv,        slave  -> master
//             win_valid, busy, done, row, col
//  Revision : 1.0  initial release
// ============================================================================
interface sobel_frame_ctrl_if #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
);
  localparam int c_ROW_W = $clog2(IMG_HEIGHT);
  localparam int c_COL_W = $clog2(IMG_WIDTH);

  logic               start;
  logic               abort;
  logic               pix_valid;
  logic               enable_lb;
  logic               enable_conv;
  logic               win_valid;
  logic               busy;
  logic               done;
  logic [c_ROW_W-1:0] row;
  logic [c_COL_W-1:0] col;

  modport master (
    output start, abort, pix_valid,
    input  enable_lb, enable_conv, win_valid, busy, done, row, col
  );

  modport slave (
    input  start, abort, pix_valid,
    output enable_lb, enable_conv, win_valid, busy, done, row, col
  );
endinterface
`default_nettype wire

// File: rtl/sobel_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_frame_ctrl
//  Purpose  : Frame sequencer for a KERNELxKERNEL Sobel engine. Walks the
//             line-buffer fill, convolution, pipeline drain and finish phases
//             and tracks the row/column of the next pixel to accept.
//  Ports    : clk        sole clock, rising edge
//             reset      asynchronous active-high reset
//             bus        sobel_frame_ctrl_if.slave (start, abort, pix_valid in;
//                        enable_lb, enable_conv, win_valid, busy, done,
//                        row, col out)
//  Options  : SOBEL_CONT_FRAME_EN - when defined, start seen in FINISH
//             launches the next frame directly (no IDLE cycle).
//  Revision : 1.0  initial release
// ============================================================================
module sobel_frame_ctrl #(
  parameter int IMG_WIDTH    = 640,
  parameter int IMG_HEIGHT   = 480,
  parameter int KERNEL       = 3,
  parameter int DRAIN_CYCLES = 4
) (
  input wire logic           clk,
  input wire logic           reset,
  sobel_frame_ctrl_if.slave  bus
);

  localparam int c_ROW_W = $clog2(IMG_HEIGHT);
  localparam int c_COL_W = $clog2(IMG_WIDTH);
  localparam int c_DRN_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [c_ROW_W-1:0] c_ROW_LAST  = c_ROW_W'(IMG_HEIGHT - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_LB    = c_ROW_W'(KERNEL - 2);
  localparam logic [c_COL_W-1:0] c_COL_LAST  = c_COL_W'(IMG_WIDTH - 1);
  localparam logic [c_COL_W-1:0] c_COL_WIN   = c_COL_W'(KERNEL - 1);
  localparam logic [c_DRN_W-1:0] c_DRN_LAST  = c_DRN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE             = 3'd0,
    LOAD_LINE_BUFFER = 3'd1,
    PROCESSING       = 3'd2,
    DRAIN            = 3'd3,
    FINISH           = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [c_ROW_W-1:0] row_q, row_d;
  logic [c_COL_W-1:0] col_q, col_d;
  logic [c_DRN_W-1:0] drain_q, drain_d;

  logic w_accept;
  logic w_last_col;

  assign w_accept   = bus.pix_valid &&
                      ((state_q == LOAD_LINE_BUFFER) || (state_q == PROCESSING));
  assign w_last_col = (col_q == c_COL_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    drain_d = drain_q;

    // Raster position advances on every accepted pixel; the last pixel of the
    // frame wraps both counters back to the origin.
    if (w_accept) begin
      if (w_last_col) begin
        col_d = '0;
        row_d = (row_q == c_ROW_LAST) ? '0 : row_q + c_ROW_W'(1);
      end else begin
        col_d = col_q + c_COL_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        // start together with abort is treated as "no request".
        if (bus.start && !bus.abort) begin
          state_d = LOAD_LINE_BUFFER;
          row_d   = '0;
          col_d   = '0;
        end
      end
      LOAD_LINE_BUFFER: begin
        if (w_accept && w_last_col && (row_q == c_ROW_LB)) begin
          state_d = PROCESSING;
        end
      end
      PROCESSING: begin
        if (w_accept && w_last_col && (row_q == c_ROW_LAST)) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        if (drain_q == c_DRN_LAST) begin
          state_d = FINISH;
          drain_d = '0;
        end else begin
          drain_d = drain_q + c_DRN_W'(1);
        end
      end
      FINISH: begin
`ifdef SOBEL_CONT_FRAME_EN
        if (bus.start) begin
          state_d = LOAD_LINE_BUFFER;
          row_d   = '0;
          col_d   = '0;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort outranks every other transition once a frame is underway.
    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
      row_d   = '0;
      col_d   = '0;
      drain_d = '0;
    end
  end

  assign bus.enable_lb   = (state_q == LOAD_LINE_BUFFER);
  assign bus.enable_conv = (state_q == PROCESSING);
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == FINISH);
  assign bus.win_valid   = (state_q == PROCESSING) && bus.pix_valid &&
                           (col_q >= c_COL_WIN);
  assign bus.row         = row_q;
  assign bus.col         = col_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sobel_frame_ctrl
//  Purpose  : Self-checking bench for sobel_frame_ctrl (W=8, H=6, K=3, D=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sobel_frame_ctrl;

  localparam int W = 8;
  localparam int H = 6;
  localparam int K = 3;
  localparam int D = 4;

  logic clk;
  logic reset;

  sobel_frame_ctrl_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();

  sobel_frame_ctrl #(
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .KERNEL      (K),
    .DRAIN_CYCLES(D)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: frame progress expressed as a pixel count.
  // phase: 0 idle, 1 streaming pixels, 2 draining, 3 finishing
  int   m_phase = 0;
  int   m_n     = 0;
  int   m_dr    = 0;
  logic cur_v   = 1'b0;

  function automatic logic [10:0] pack(input logic lb, cv, wn, by, dn,
                                       input int row, input int col);
    logic [2:0] r;
    logic [2:0] c;
    r = row[2:0];
    c = col[2:0];
    return {lb, cv, wn, by, dn, r, c};
  endfunction

  function automatic logic [10:0] model_out(input logic v);
    int row;
    int col;
    logic lb;
    logic cv;
    logic wn;
    row = 0; col = 0; lb = 1'b0; cv = 1'b0; wn = 1'b0;
    if (m_phase == 1) begin
      row = m_n / W;
      col = m_n % W;
      lb  = (m_n < (K - 1) * W);
      cv  = !lb;
      wn  = cv && v && (col >= K - 1);
    end
    return pack(lb, cv, wn, m_phase != 0, m_phase == 3, row, col);
  endfunction

  function automatic void model_update(input logic s, a, v);
    if (a && m_phase != 0) begin
      m_phase = 0; m_n = 0; m_dr = 0;
    end else begin
      case (m_phase)
        0: if (s && !a) begin m_phase = 1; m_n = 0; end
        1: if (v) begin
             m_n++;
             if (m_n == W * H) begin m_phase = 2; m_n = 0; m_dr = 0; end
           end
        2: begin
             m_dr++;
             if (m_dr == D) m_phase = 3;
           end
        default: begin
`ifdef SOBEL_CONT_FRAME_EN
          if (s) begin m_phase = 1; m_n = 0; end
          else m_phase = 0;
`else
          m_phase = 0;
`endif
        end
      endcase
    end
  endfunction

  function automatic logic [10:0] dut_out();
    return {bus.enable_lb, bus.enable_conv, bus.win_valid, bus.busy,
            bus.done, bus.row, bus.col};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_model(input string nm);
    chk(nm, int'(dut_out()), int'(model_out(cur_v)));
  endtask

  task automatic apply(input logic s, a, v);
    @(negedge clk);
    bus.start = s; bus.abort = a; bus.pix_valid = v; cur_v = v;
    #1;
  endtask

  task automatic advance(input logic s, a, v);
    @(posedge clk);
    model_update(s, a, v);
  endtask

  task automatic step(input logic s, a, v, input string nm);
    apply(s, a, v);
    check_model(nm);
    advance(s, a, v);
  endtask

  task automatic run_frame(input bit toggle, output int lb, cv, drn, dn,
                           win, winbad, acc);
    bit   seen;
    logic v;
    lb = 0; cv = 0; drn = 0; dn = 0; win = 0; winbad = 0; acc = 0;
    seen = 1'b0;
    step(1'b1, 1'b0, 1'b1, "frame_start");
    for (int i = 1; i < 400 && !seen; i++) begin
      v = toggle ? logic'(i % 2 == 0) : 1'b1;
      apply(1'b0, 1'b0, v);
      check_model("frame");
      if (bus.enable_lb)   lb++;
      if (bus.enable_conv) cv++;
      if (bus.busy && !bus.enable_lb && !bus.enable_conv && !bus.done) drn++;
      if (bus.done) begin dn++; seen = 1'b1; end
      if (bus.win_valid) begin win++; if (bus.col < 2) winbad++; end
      if (v && (bus.enable_lb || bus.enable_conv)) acc++;
      advance(1'b0, 1'b0, v);
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 1'b1);
      check_model("frame_tail");
      if (bus.done) dn++;
      advance(1'b0, 1'b0, 1'b1);
    end
  endtask

  typedef struct {
    logic s, a, v;
    logic lb, cv, wn, by, dn;
    int   row, col;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int lb, cv, drn, dn, win, winbad, acc, dones;
    bit prev_done;

    tbl[0] = '{1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0, 0,0}; // abort in IDLE
    tbl[1] = '{1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0, 0,0}; // start+abort
    tbl[2] = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0, 0,0}; // pv ignored
    tbl[3] = '{1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 0,0}; // start
    tbl[4] = '{1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1,1'b0, 0,0}; // LOAD px0
    tbl[5] = '{1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0, 0,1}; // stall
    tbl[6] = '{1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1,1'b0, 0,1}; // LOAD px1
    tbl[7] = '{1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b1,1'b0, 0,2}; // abort
    tbl[8] = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 0,0}; // back idle

    // Reset: outputs stay 0 even with requests driven.
    reset = 1'b1;
    bus.start = 1'b1; bus.abort = 1'b0; bus.pix_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("reset_state", int'(dut_out()), 0);
    end
    @(negedge clk);
    reset = 1'b0; bus.start = 1'b0; bus.pix_valid = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].s, tbl[i].a, tbl[i].v);
      chk($sformatf("vec%0d", i), int'(dut_out()),
          int'(pack(tbl[i].lb, tbl[i].cv, tbl[i].wn, tbl[i].by, tbl[i].dn,
                    tbl[i].row, tbl[i].col)));
      advance(tbl[i].s, tbl[i].a, tbl[i].v);
    end

    // Full frame with pix_valid held high.
    run_frame(1'b0, lb, cv, drn, dn, win, winbad, acc);
    chk("held_lb_cycles",   lb,     16);
    chk("held_conv_cycles", cv,     32);
    chk("held_drain",       drn,    D);
    chk("held_done",        dn,     1);
    chk("held_win",         win,    24);
    chk("held_win_lowcol",  winbad, 0);

    // Frame with pix_valid toggling.
    run_frame(1'b1, lb, cv, drn, dn, win, winbad, acc);
    chk("tog_lb_cycles", lb,  32);
    chk("tog_accepted",  acc, 48);
    chk("tog_done",      dn,  1);

    // Abort on the 10th PROCESSING pixel.
    step(1'b1, 1'b0, 1'b0, "abort_start");
    for (int i = 0; i < 200 && !(m_phase == 1 && m_n == (K - 1) * W + 9); i++)
      step(1'b0, 1'b0, 1'b1, "abort_run");
    apply(1'b0, 1'b1, 1'b1);
    chk("abort_cycle_conv", int'(bus.enable_conv), 1);
    advance(1'b0, 1'b1, 1'b1);
    apply(1'b0, 1'b0, 1'b1);
    chk("abort_idle", int'(dut_out()), 0);
    advance(1'b0, 1'b0, 1'b1);
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      apply(1'b0, 1'b0, 1'b1);
      if (bus.done) dn++;
      advance(1'b0, 1'b0, 1'b1);
    end
    chk("abort_no_done", dn, 0);
    run_frame(1'b0, lb, cv, drn, dn, win, winbad, acc);
    chk("post_abort_lb",   lb, 16);
    chk("post_abort_conv", cv, 32);
    chk("post_abort_done", dn, 1);

    // Reset during DRAIN.
    step(1'b1, 1'b0, 1'b1, "drain_start");
    for (int i = 0; i < 200 && !(m_phase == 2 && m_dr == 2); i++)
      step(1'b0, 1'b0, 1'b1, "drain_run");
    @(negedge clk);
    bus.start = 1'b0; bus.pix_valid = 1'b0; cur_v = 1'b0;
    chk("pre_reset_busy", int'(bus.busy), 1);
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", int'(dut_out()), 0);
    m_phase = 0; m_n = 0; m_dr = 0;
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      apply(1'b0, 1'b0, 1'b0);
      check_model("post_reset");
      if (bus.done) dn++;
      advance(1'b0, 1'b0, 1'b0);
    end
    chk("post_reset_no_done", dn, 0);

    // Back-to-back frames with start held.
    dones = 0; prev_done = 1'b0;
    for (int i = 0; i < 400 && dones < 2; i++) begin
      apply(1'b1, 1'b0, 1'b1);
      check_model("b2b");
      if (prev_done) begin
`ifdef SOBEL_CONT_FRAME_EN
        chk("b2b_lb_after_done", int'(bus.enable_lb), 1);
`else
        chk("b2b_idle_after_done", int'(bus.busy), 0);
`endif
      end
      prev_done = bus.done;
      if (bus.done) dones++;
      advance(1'b1, 1'b0, 1'b1);
    end
    chk("b2b_done_count", dones, 2);
    apply(1'b1, 1'b0, 1'b1);
    chk("b2b_after_second_done_lb", int'(bus.enable_lb),
`ifdef SOBEL_CONT_FRAME_EN
        1
`else
        0
`endif
    );
    advance(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, "b2b_abort");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic s, a, v;
      s = logic'($urandom % 4 == 0);
      a = logic'($urandom % 64 == 0);
      v = logic'($urandom % 2);
      step(s, a, v, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sobel_frame_ctrl.md
SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per image row; SHALL be at least KERNEL.
REQ-002 Parameter IMG_HEIGHT, default 480, rows per frame; SHALL be at least KERNEL.
REQ-003 Parameter KERNEL, default 3, convolution window size; SHALL be at least 2.
REQ-004 Parameter DRAIN_CYCLES, default 4, pipeline flush cycles after the last pixel; SHALL be at least 1.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  frame start request from the regfile, level-sampled.
REQ-008 abort  input  1  cancels the frame in progress.
REQ-009 pix_valid  input  1  an input pixel is present this cycle.
REQ-010 enable_lb  output  1  line buffer fill phase.
REQ-011 enable_conv  output  1  convolution phase.
REQ-012 win_valid  output  1  the accepted pixel completes a full KERNELxKERNEL window.
REQ-013 row  output  $clog2(IMG_HEIGHT)  row of the next pixel to accept.
REQ-014 col  output  $clog2(IMG_WIDTH)  column of the next pixel to accept.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  single-cycle frame-complete pulse.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, LOAD_LINE_BUFFER, PROCESSING, DRAIN, FINISH.
REQ-018 A pixel is accepted when pix_valid=1 in LOAD_LINE_BUFFER or PROCESSING; pix_valid SHALL be ignored in all other states.
REQ-019 On an accepted pixel, col SHALL increment; at IMG_WIDTH-1, col SHALL wrap to 0 and row SHALL increment.
REQ-020 IDLE with start=1: next state LOAD_LINE_BUFFER; row and col SHALL clear to 0.
REQ-021 LOAD_LINE_BUFFER: enable_lb=1; on the accepted pixel at row=KERNEL-2, col=IMG_WIDTH-1, next state PROCESSING.
REQ-022 PROCESSING: enable_conv=1; win_valid=1 exactly when a pixel is accepted and col>=KERNEL-1.
REQ-023 PROCESSING: on the accepted pixel at row=IMG_HEIGHT-1, col=IMG_WIDTH-1, next state DRAIN; row and col SHALL wrap to 0.
REQ-024 DRAIN SHALL last exactly DRAIN_CYCLES cycles, counted by an internal counter, then go to FINISH.
REQ-025 FINISH SHALL last one cycle with done=1, then go to IDLE (see REQ-033).
REQ-026 enable_lb, enable_conv, busy and done SHALL be combinational decodes of the state only; win_valid SHALL be combinational from state, pix_valid and col.
REQ-027 start outside IDLE (and outside FINISH when REQ-033 applies) SHALL be ignored.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE next cycle, clear row, col and the drain counter, and suppress done; abort SHALL have priority over every other transition.
REQ-029 abort in IDLE SHALL have no effect; simultaneous start and abort in IDLE SHALL leave the FSM in IDLE.

Reset
REQ-030 While reset=1: state SHALL be IDLE, and row, col and the drain counter SHALL be 0.
REQ-031 Every output SHALL therefore be 0 during reset.
REQ-032 Reset asserted mid-frame SHALL take effect immediately, without waiting for a clock edge, and no done pulse SHALL follow.

Configuration
REQ-033 SOBEL_CONT_FRAME_EN defined: FINISH with start=1 SHALL go directly to LOAD_LINE_BUFFER with row and col cleared (back-to-back frames, no IDLE cycle); FINISH with start=0 SHALL go to IDLE.
REQ-034 SOBEL_CONT_FRAME_EN undefined: FINISH SHALL always go to IDLE, ignoring start.

Verification
REQ-035 Parameters W=8, H=6, K=3, D=4; start, then pix_valid held 1 -> enable_lb for 16 cycles, enable_conv for 32 cycles, DRAIN for 4 cycles, done high for exactly 1 cycle.
REQ-036 Same setup -> win_valid asserted on 24 of the 32 PROCESSING pixels, low whenever col is 0 or 1.
REQ-037 pix_valid toggled 1,0,1,0 -> row and col advance only on valid cycles; LOAD lasts 32 cycles; total pixels accepted is 48.
REQ-038 abort on the 10th PROCESSING pixel -> IDLE next cycle; row=0, col=0, no done; the next start gives a full, correct frame.
REQ-039 reset asserted during DRAIN -> all outputs 0 immediately; no done after reset is released.
REQ-040 With SOBEL_CONT_FRAME_EN and start held 1 -> after done, enable_lb is high on the very next cycle, and two frames complete with two done pulses; without the macro -> one IDLE cycle between frames.
